// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson counter phase monitor.
// Holds the FSM state encoding and the code-to-phase lookup table.
package johnson_pkg;

   localparam int PHASE_W    = 3;
   localparam int NUM_PHASES = 8;
   localparam int CODE_W     = 4;

   typedef enum logic [1:0] {
      ACQUIRE = 2'd0,
      LOCKED  = 2'd1,
      FAULT   = 2'd2
   } mon_state_t;

   // Entry i is the {q0,q1,q2,q3} code for phase i; entry 0 is the rightmost.
   localparam logic [NUM_PHASES-1:0][CODE_W-1:0] PHASE_CODES = {
      4'b0001, 4'b0011, 4'b0111, 4'b1111,
      4'b1110, 4'b1100, 4'b1000, 4'b0000
   };

endpackage

// File: rtl/johnson_decode.sv
// Combinational decoder: maps a 4-bit Johnson code to its phase index.
// legal is low for the eight codes that never occur in a healthy counter.
module johnson_decode
   import johnson_pkg::*;
(
   input  logic [CODE_W-1:0]  code,
   output logic [PHASE_W-1:0] idx,
   output logic               legal
);

   always_comb begin
      // NOTE: defaults first so every path assigns every output and no latch is inferred.
      idx   = '0;
      legal = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (code == PHASE_CODES[i]) begin
            idx   = PHASE_W'(i);
            legal = 1'b1;
         end
      end
   end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Validates and decodes a 4-bit Johnson counter, tracks lock and revolutions.
// Define JOHNSON_SYNC_IN_EN to pass q0..q3 through a 2-flop synchronizer first.
module johnson_phase_monitor
   import johnson_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int LOCK_CNT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  q0,
   input  logic                  q1,
   input  logic                  q2,
   input  logic                  q3,
   input  logic                  err_clr,
   output logic [PHASE_W-1:0]    phase,
   output logic [NUM_PHASES-1:0] phase_onehot,
   output logic                  phase_valid,
   output logic                  wrap,
   output logic [CNT_W-1:0]      cycle_count,
   output logic                  locked,
   output logic                  err_illegal,
   output logic                  err_skip
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);

   logic [CODE_W-1:0] code;

`ifdef JOHNSON_SYNC_IN_EN
   logic [CODE_W-1:0] sync_1;
   logic [CODE_W-1:0] sync_2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         // NOTE: non-blocking so sync_2 takes the old sync_1, giving two real flop stages.
         sync_1 <= {q0, q1, q2, q3};
         sync_2 <= sync_1;
      end
   end

   assign code = sync_2;
`else
   assign code = {q0, q1, q2, q3};
`endif

   logic [PHASE_W-1:0] idx;
   logic               legal;

   johnson_decode u_decode (
      .code  (code),
      .idx   (idx),
      .legal (legal)
   );

   mon_state_t            state, state_next;
   logic [PHASE_W-1:0]    prev_idx, prev_idx_next;
   logic                  prev_valid, prev_valid_next;
   logic [RUN_W-1:0]      run, run_next, run_inc;
   logic [PHASE_W-1:0]    phase_next;
   logic [NUM_PHASES-1:0] onehot_next;
   logic                  valid_next, wrap_next;
   logic [CNT_W-1:0]      count_next;
   logic                  set_illegal, set_skip;
   logic                  successor;

   assign run_inc   = run + RUN_W'(1);
   assign successor = legal && prev_valid && (idx == prev_idx + PHASE_W'(1));

   always_comb begin
      state_next      = state;
      prev_idx_next   = prev_idx;
      prev_valid_next = prev_valid;
      run_next        = run;
      phase_next      = phase;
      onehot_next     = phase_onehot;
      valid_next      = phase_valid;
      wrap_next       = 1'b0;
      count_next      = cycle_count;
      set_illegal     = 1'b0;
      set_skip        = 1'b0;

      // FAULT ignores the input entirely, including the previous-sample history.
      if (state != FAULT) begin
         prev_valid_next = legal;
         if (legal) prev_idx_next = idx;
      end

      unique case (state)
         ACQUIRE: begin
            if (!legal) begin
               set_illegal = 1'b1;
               run_next    = '0;
            end else if (successor) begin
               run_next = run_inc;
               if (run_inc == RUN_W'(LOCK_CNT)) begin
                  state_next  = LOCKED;
                  valid_next  = 1'b1;
                  phase_next  = idx;
                  onehot_next = NUM_PHASES'(1) << idx;
               end
            end else begin
               run_next = RUN_W'(1);
            end
         end
         LOCKED: begin
            if (!legal) begin
               set_illegal = 1'b1;
               state_next  = FAULT;
               valid_next  = 1'b0;
               onehot_next = '0;
            end else if (successor) begin
               phase_next  = idx;
               onehot_next = NUM_PHASES'(1) << idx;
               if (prev_idx == PHASE_W'(NUM_PHASES - 1) && idx == '0) begin
                  wrap_next = 1'b1;
                  if (cycle_count != '1) count_next = cycle_count + CNT_W'(1);
               end
            end else begin
               set_skip    = 1'b1;
               state_next  = ACQUIRE;
               run_next    = RUN_W'(1);
               valid_next  = 1'b0;
               onehot_next = '0;
            end
         end
         FAULT: begin
            if (err_clr) begin
               state_next      = ACQUIRE;
               run_next        = '0;
               prev_valid_next = 1'b0;
            end
         end
         default: state_next = ACQUIRE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ACQUIRE;
         prev_idx     <= '0;
         prev_valid   <= 1'b0;
         run          <= '0;
         phase        <= '0;
         phase_onehot <= '0;
         phase_valid  <= 1'b0;
         wrap         <= 1'b0;
         cycle_count  <= '0;
         err_illegal  <= 1'b0;
         err_skip     <= 1'b0;
      end else begin
         state        <= state_next;
         prev_idx     <= prev_idx_next;
         prev_valid   <= prev_valid_next;
         run          <= run_next;
         phase        <= phase_next;
         phase_onehot <= onehot_next;
         phase_valid  <= valid_next;
         wrap         <= wrap_next;
         cycle_count  <= count_next;
         // A new error on the same edge as err_clr wins over the clear.
         err_illegal  <= (err_illegal & ~err_clr) | set_illegal;
         err_skip     <= (err_skip & ~err_clr) | set_skip;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: doc/johnson_phase_monitor.md
Name: johnson_phase_monitor

Overview:
- Sits directly downstream of the 4-bit Johnson counter and consumes its q0..q3 outputs.
- Each clock it validates the code, decodes it to a 3-bit phase index and a one-hot phase strobe, and checks that each sample is the exact successor of the previous one.
- Counts completed 8-phase revolutions and flags illegal codes or skipped/held steps with sticky error bits.
- Gives downstream logic a qualified phase and a health indication for the counter.

Parameters:
- CNT_W, 16, width of the revolution counter cycle_count.
- LOCK_CNT, 4, number of consecutive legal, successive samples required to reach lock (legal range 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset (0 = reset).
- q0  input  1  Johnson counter bit 0 (MSB of code).
- q1  input  1  Johnson counter bit 1.
- q2  input  1  Johnson counter bit 2.
- q3  input  1  Johnson counter bit 3 (LSB of code).
- err_clr  input  1  synchronous clear of sticky errors and exit from FAULT.
- phase  output  3  decoded phase index 0..7.
- phase_onehot  output  8  one-hot of phase; all zero when phase_valid=0.
- phase_valid  output  1  high only in LOCKED.
- wrap  output  1  one-cycle pulse on each 7->0 step while LOCKED.
- cycle_count  output  CNT_W  completed revolutions, saturating.
- locked  output  1  state==LOCKED.
- err_illegal  output  1  sticky: a non-Johnson code was sampled.
- err_skip  output  1  sticky: a legal but non-successor code was sampled while LOCKED.

Behaviour:
- Code = {q0,q1,q2,q3}. Legal sequence and index: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7. The other 8 codes are illegal.
- Registered state: prev_idx, prev_valid, run counter, FSM {ACQUIRE, LOCKED, FAULT}. All outputs are registered.
- Latency: 1 clk edge from input sample to outputs.
- Reset (reset=0, asynchronous): every output is 0; state=ACQUIRE, run=0, prev_valid=0, prev_idx=0.
- Successor rule: idx == (prev_idx+1) mod 8 and prev_valid=1. A hold on the same code is a non-successor.
- Every legal sample loads prev_idx<=idx and prev_valid<=1. Every illegal sample clears prev_valid.
- ACQUIRE:
  - Illegal code: err_illegal<=1, run<=0.
  - Legal non-successor: run<=1.
  - Successor: run<=run+1. When run+1==LOCK_CNT: state<=LOCKED, phase_valid<=1, phase<=idx on that same edge.
  - err_skip is never set in ACQUIRE. phase_valid=0.
- LOCKED:
  - Successor: phase<=idx and phase_onehot<=1<<idx.
  - wrap<=1 when prev_idx=7 and idx=0; cycle_count increments on that edge and saturates at all-ones.
  - Legal non-successor: err_skip<=1, state<=ACQUIRE, run<=1, phase_valid<=0.
  - Illegal code: err_illegal<=1, state<=FAULT, phase_valid<=0.
- FAULT:
  - Inputs are ignored except for err_clr; phase_valid=0.
  - err_clr=1: state<=ACQUIRE, run<=0, prev_valid<=0.
- Output hold rules:
  - phase holds its last value when phase_valid=0; phase_onehot is forced to 0.
  - wrap is 0 except for the single pulse.
- err_clr in any state clears err_illegal and err_skip. If an error event occurs on the same edge, set wins.
- cycle_count is cleared only by reset. It retains its value through ACQUIRE and FAULT.
- Reset asserted mid-operation clears everything immediately, with no clock edge required. Operation resumes at the first rising edge after reset deasserts.

Optional Feature:
- Macro: JOHNSON_SYNC_IN_EN.
- Defined: q0..q3 pass through a 2-flop synchronizer, reset to 0, before decode. Input-to-output latency becomes 3 edges. Use when the counter is in another clock domain.
- Undefined: inputs are decoded directly; latency is 1.

Decomposition:
- Package johnson_pkg holds:
  - the FSM state enum;
  - PHASE_W=3 and NUM_PHASES=8;
  - the code-to-index table constants.
- One sub-module, johnson_decode: combinational, 4-bit code in, idx[2:0] and legal out. It is instantiated once.
- The FSM, counters and synchronizer stay in the top level.

Test Plan:
- Clean lock: LOCK_CNT=4; after reset, feed 0000,1000,1100,1110 on successive edges -> locked=1 and phase_valid=1 after 4th edge with phase=3, phase_onehot=8'h08. Continue through 0001 then 0000 -> wrap pulses for exactly one cycle, cycle_count=1.
- Illegal code: while LOCKED, drive 1010 -> next edge err_illegal=1, locked=0, phase_valid=0, phase_onehot=0, cycle_count unchanged. Pulse err_clr -> err_illegal=0, state ACQUIRE. Relock after 4 clean samples.
- Hold/skip: while LOCKED at phase 2, repeat 1100 -> err_skip=1, locked=0. Three further successive codes 1110,1111,0111 -> locked=1, phase=5.
- Saturation: CNT_W=2; run 5 full revolutions while LOCKED -> cycle_count=3 and stays 3; wrap still pulses each revolution.
- Async reset mid-run: assert reset=0 between clock edges while LOCKED with cycle_count=2 -> all outputs 0 before the next edge. After release, 4 clean samples relock with cycle_count=0.
- Error vs clear: err_clr=1 on the same edge as an illegal code -> err_illegal=1.
- JOHNSON_SYNC_IN_EN defined: repeat the clean-lock scenario -> locked asserts 2 edges later than in the non-synchronized build.
